// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters,
// with SETUP/ACCESS sequencing, read-data/error return and wait-state timeout.
//
//   state  | meaning
//   IDLE   | no transfer; arbitrate among requesters not completing this cycle
//   SETUP  | psel high, penable low; command fields latched
//   ACCESS | psel and penable high; wait for pready or timeout
module apb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]     done,
  output logic [31:0]            rdata,
  output logic                   err,
  output logic                   timeout,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic [31:0]            paddr,
  output logic [31:0]            pwdata,
  output logic                   pwrite,
  output logic                   psel,
  output logic                   penable,
  input  logic                   pready,
  input  logic [31:0]            prdata,
  input  logic                   pslverr
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]   r_wait, w_wait_nxt;
  logic [IDX_W-1:0]   r_grant, w_grant_nxt;
  logic [31:0]        r_paddr, w_paddr_nxt;
  logic [31:0]        r_pwdata, w_pwdata_nxt;
  logic               r_pwrite, w_pwrite_nxt;
  logic               r_psel, w_psel_nxt;
  logic               r_penable, w_penable_nxt;
  logic               r_busy, w_busy_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic [31:0]        r_rdata, w_rdata_nxt;
  logic               r_err, w_err_nxt;
  logic               r_timeout, w_timeout_nxt;

  logic [NUM_REQ-1:0] w_elig;
  logic               w_pick_vld;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_wait_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_wait    <= '0;
      r_grant   <= '0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwrite  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_wait    <= w_wait_nxt;
      r_grant   <= w_grant_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // Requester completing this cycle is masked so it cannot be regranted at once.
  always_comb begin
    int j;
    j           = 0;
    w_elig      = req & ~r_done;
    w_pick_vld  = 1'b0;
    w_pick_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      j = (int'(r_ptr) + i) % NUM_REQ;
      if (w_elig[j]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = IDX_W'(j);
      end
    end
    w_wait_hit  = (TIMEOUT != 0) && (r_wait == CNT_W'(TIMEOUT - 1));

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_pick_vld) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (pready || w_wait_hit) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_wait_nxt    = r_wait;
    w_grant_nxt   = r_grant;
    w_paddr_nxt   = r_paddr;
    w_pwdata_nxt  = r_pwdata;
    w_pwrite_nxt  = r_pwrite;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_busy_nxt    = r_busy;
    w_done_nxt    = '0;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = 1'b0;
    w_timeout_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        if (w_pick_vld) begin
          w_grant_nxt   = w_pick_idx;
          w_paddr_nxt   = req_addr[32*int'(w_pick_idx) +: 32];
          w_pwdata_nxt  = req_wdata[32*int'(w_pick_idx) +: 32];
          w_pwrite_nxt  = req_write[w_pick_idx];
          w_psel_nxt    = 1'b1;
          w_busy_nxt    = 1'b1;
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_wait_nxt    = '0;
      end
      S_ACCESS: begin
        if (pready || w_wait_hit) begin
          w_psel_nxt           = 1'b0;
          w_penable_nxt        = 1'b0;
          w_busy_nxt           = 1'b0;
          w_done_nxt[r_grant]  = 1'b1;
          w_ptr_nxt            = (r_grant == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
          if (pready) begin
            w_err_nxt = pslverr;
            if (!r_pwrite) w_rdata_nxt = prdata;
          end else begin
            w_err_nxt     = 1'b1;
            w_timeout_nxt = 1'b1;
          end
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign done      = r_done;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign timeout   = r_timeout;
  assign grant_idx = r_grant;
  assign busy      = r_busy;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
Round-robin arbiter and transfer sequencer that shares one APB master port among NUM_REQ local requesters. Each requester posts a single read or write command. The block grants one requester at a time, drives the APB SETUP/ACCESS phases, returns read data and an error status, and aborts transfers that exceed a wait-state timeout. It sits between on-chip command sources and the APB slave fabric, and replaces hard-wired single-master sequencing.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, grant index width, ceil(log2(NUM_REQ))
TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester command request, held until done
req_write  in  NUM_REQ  per-requester direction (1 = write)
req_addr  in  NUM_REQ*32  per-requester address; slice i = [32*i+31:32*i]
req_wdata  in  NUM_REQ*32  per-requester write data, same slicing
done  out  NUM_REQ  one-cycle completion pulse to the granted requester
rdata  out  32  read data of the last completed transfer, valid with done
err  out  1  error flag of the last completed transfer, valid with done
timeout  out  1  one-cycle pulse when a transfer is aborted by timeout
grant_idx  out  IDX_W  index of the requester owning the current transfer
busy  out  1  high in SETUP and ACCESS
paddr  out  32  APB address
pwdata  out  32  APB write data
pwrite  out  1  APB direction
psel  out  1  APB select
penable  out  1  APB enable
pready  in  1  APB ready
prdata  in  32  APB read data
pslverr  in  1  APB slave error

Behaviour:
- Synchronous active-low reset, sampled on the rising clk edge only. Reset values: state=IDLE; psel, penable, pwrite, busy, done, err, timeout = 0; paddr, pwdata, rdata = 0; grant_idx = 0; rr pointer = 0; wait counter = 0. Reset asserted mid-transfer drops psel/penable on the next edge and emits no done.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Eligible set = req, with the bit done[i] currently high masked out.
  - If the eligible set is non-empty, pick the first set bit scanning from index ptr upward with wrap.
  - Latch grant_idx, paddr, pwdata, pwrite from that requester's slices. Set psel=1, penable=0, busy=1. Go to SETUP.
  - Otherwise stay in IDLE with psel=0.
- SETUP: penable=1; go to ACCESS. Clear the wait counter.
- ACCESS, pready=1:
  - psel=0, penable=0, busy=0.
  - done[grant_idx]=1 for exactly one cycle; rdata=prdata when reading (hold the previous rdata when writing); err=pslverr.
  - ptr = grant_idx+1 mod NUM_REQ. Go to IDLE.
- ACCESS, pready=0: increment the wait counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1: perform the same completion with err=1, rdata unchanged, and timeout=1 for one cycle.
- Latency with zero wait states: req sampled at edge k, psel=1 after k+1, penable=1 after k+2, done after k+3. Transfers are separated by at least one IDLE cycle (psel low).
- Requesters must hold req and command fields stable until done, then drop req. The done-cycle mask prevents an immediate regrant to the completing requester; a requester that still asserts req afterwards is treated as a new command.
- paddr, pwdata and pwrite stay stable from SETUP through the end of ACCESS. Input changes from the granted requester mid-transfer are ignored.
- done, timeout and err are pulses or valid-with-done only. err is cleared to 0 on the next cycle.

Test Plan:
- Single write: req=4'b0001, addr0=0x10, wdata0=0x12345678, write, pready=1 -> psel 1 cycle before penable, paddr=0x10, pwdata=0x12345678, done=4'b0001 at edge k+3, err=0.
- Read with 3 wait states: req1 read at addr 0x20, pready low 3 ACCESS cycles, prdata=0xCAFEF00D -> done[1] after 4 ACCESS cycles, rdata=0xCAFEF00D, penable held high throughout.
- Round robin: req=4'b1111 held continuously with each requester re-asserting after done -> grant order 0,1,2,3,0; no requester granted twice consecutively while others are pending.
- Slave error and timeout: pslverr=1 with pready=1 -> err=1 with done. Then pready stuck at 0 with TIMEOUT=16 -> abort after 16 ACCESS cycles, timeout=1, err=1, psel=0.
- Reset mid-ACCESS: rst_n=0 for one edge while penable=1 -> next cycle psel=penable=0, done=0, grant_idx=0. After release, req=4'b0110 grants requester 1 first.
- Single persistent requester: req=4'b0100 never dropped -> back-to-back transfers with exactly one IDLE cycle between done and the next psel, and done[2] pulsing once per transfer.
